// File: rtl/merlin_fifo_reader_pkg.sv
// Shared types for the FIFO read-side stream adapter.
package merlin_fifo_reader_pkg;

  // Occupancy of the head/skid pair.
  typedef enum logic [1:0] {
    OccZero = 2'b00,
    OccOne  = 2'b01,
    OccTwo  = 2'b10
  } occ_e;

  // Output is valid whenever at least the head register is occupied.
  function automatic logic occ_valid(input occ_e occ);
    return occ != OccZero;
  endfunction

endpackage

// File: rtl/merlin_fifo.sv
// Show-ahead synchronous FIFO: dout_o presents the oldest entry whenever empty_o is low.
module merlin_fifo #(
  parameter int unsigned C_FIFO_WIDTH = 32,
  parameter int unsigned C_FIFO_DEPTH = 8
) (
  input  logic                    clk_i,
  input  logic                    resetb_i,
  input  logic                    clk_en_i,
  input  logic                    flush_i,
  input  logic                    wr_i,
  input  logic [C_FIFO_WIDTH-1:0] din_i,
  input  logic                    rd_i,
  output logic [C_FIFO_WIDTH-1:0] dout_o,
  output logic                    empty_o,
  output logic                    full_o
);

  localparam int unsigned PtrW = $clog2(C_FIFO_DEPTH);

  logic [C_FIFO_WIDTH-1:0] mem_q [C_FIFO_DEPTH];
  logic [PtrW:0]           wr_ptr_q, wr_ptr_d;
  logic [PtrW:0]           rd_ptr_q, rd_ptr_d;
  logic                    do_wr, do_rd;

  // Extra pointer MSB distinguishes full from empty.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                   (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign dout_o  = mem_q[rd_ptr_q[PtrW-1:0]];

  assign do_wr = clk_en_i & ~flush_i & wr_i & ~full_o;
  assign do_rd = clk_en_i & ~flush_i & rd_i & ~empty_o;

  // Pointer next-state; flush empties the queue.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clk_en_i && flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + (PtrW + 1)'(do_wr);
      rd_ptr_d = rd_ptr_q + (PtrW + 1)'(do_rd);
    end
  end

  // Pointer registers.
  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents need no reset.
  always_ff @(posedge clk_i) begin
    if (do_wr) begin
      mem_q[wr_ptr_q[PtrW-1:0]] <= din_i;
    end
  end

endmodule

// File: rtl/merlin_fifo_reader.sv
// Pops a show-ahead FIFO and re-presents entries as a registered valid/ready stream.
// A head+skid pair lets the pop strobe ignore rdy_i while still sustaining one beat per cycle.
module merlin_fifo_reader
  import merlin_fifo_reader_pkg::*;
#(
  parameter int unsigned C_WIDTH     = 32,
  parameter int unsigned C_CNT_WIDTH = 16
) (
  input  logic                   clk_i,
  input  logic                   resetb_i,
  input  logic                   clk_en_i,
  input  logic                   flush_i,
  input  logic                   fifo_empty_i,
  input  logic [C_WIDTH-1:0]     fifo_dout_i,
  output logic                   fifo_rd_o,
  output logic                   vld_o,
  input  logic                   rdy_i,
  output logic [C_WIDTH-1:0]     data_o,
  output logic [C_CNT_WIDTH-1:0] cnt_o
);

  localparam logic [C_CNT_WIDTH-1:0] CntOne = C_CNT_WIDTH'(1);

  occ_e                   occ_q, occ_d;
  logic [C_WIDTH-1:0]     head_q, head_d;
  logic [C_WIDTH-1:0]     skid_q, skid_d;
  logic [C_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   pop, acc;

  assign vld_o  = occ_valid(occ_q);
  assign data_o = head_q;
  assign cnt_o  = cnt_q;

  // Pop whenever there is room; gating with resetb_i keeps the strobe low during reset.
  assign pop       = clk_en_i & ~flush_i & ~fifo_empty_i & (occ_q != OccTwo) & resetb_i;
  assign fifo_rd_o = pop;
  assign acc       = clk_en_i & vld_o & rdy_i & ~flush_i;

  // Occupancy, data movement and beat counter next-state; flush overrides everything.
  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    skid_d = skid_q;
    cnt_d  = cnt_q;
    if (clk_en_i) begin
      if (flush_i) begin
        occ_d = OccZero;
        cnt_d = '0;
      end else begin
        if (acc) begin
          cnt_d = cnt_q + CntOne;
        end
        case (occ_q)
          OccZero: begin
            if (pop) begin
              occ_d  = OccOne;
              head_d = fifo_dout_i;
            end
          end
          OccOne: begin
            if (acc && pop) begin
              head_d = fifo_dout_i;
            end else if (acc) begin
              occ_d = OccZero;
            end else if (pop) begin
              occ_d  = OccTwo;
              skid_d = fifo_dout_i;
            end
          end
          OccTwo: begin
            if (acc) begin
              occ_d  = OccOne;
              head_d = skid_q;
            end
          end
          default: occ_d = OccZero;
        endcase
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      occ_q  <= OccZero;
      head_q <= '0;
      skid_q <= '0;
      cnt_q  <= '0;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      skid_q <= skid_d;
      cnt_q  <= cnt_d;
    end
  end

`ifdef RV_ASSERTS_ON
  a_no_pop_when_empty: assert property (@(posedge clk_i) disable iff (!resetb_i)
    !(fifo_rd_o && fifo_empty_i));
  a_occ_legal: assert property (@(posedge clk_i) disable iff (!resetb_i)
    occ_q inside {OccZero, OccOne, OccTwo});
  a_data_hold: assert property (@(posedge clk_i) disable iff (!resetb_i)
    (vld_o && !rdy_i && !flush_i) |=> $stable(data_o));
`endif

endmodule

// File: tb/tb_merlin_fifo_reader.sv
// Directed bench: merlin_fifo feeding merlin_fifo_reader, with a data/count scoreboard.
module tb_merlin_fifo_reader;
  import merlin_fifo_reader_pkg::*;

  logic        clk_i = 1'b0;
  logic        resetb = 1'b0;
  logic        clk_en = 1'b1;
  logic        flush = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] din = '0;
  logic        rdy = 1'b0;

  logic        fifo_empty, fifo_full, fifo_rd, fifo_rd2;
  logic [31:0] fifo_dout;
  logic        vld, vld2;
  logic [31:0] data, data2;
  logic [15:0] cnt;
  logic [1:0]  cnt2;

  int checks = 0;
  int failures = 0;
  int pops = 0;
  logic [15:0] exp_cnt = '0;
  logic [31:0] sb[$];

  always #5 clk_i = ~clk_i;

  merlin_fifo #(.C_FIFO_WIDTH(32), .C_FIFO_DEPTH(8)) u_fifo (
    .clk_i   (clk_i),
    .resetb_i(resetb),
    .clk_en_i(clk_en),
    .flush_i (flush),
    .wr_i    (wr),
    .din_i   (din),
    .rd_i    (fifo_rd),
    .dout_o  (fifo_dout),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  merlin_fifo_reader #(.C_WIDTH(32), .C_CNT_WIDTH(16)) dut (
    .clk_i       (clk_i),
    .resetb_i    (resetb),
    .clk_en_i    (clk_en),
    .flush_i     (flush),
    .fifo_empty_i(fifo_empty),
    .fifo_dout_i (fifo_dout),
    .fifo_rd_o   (fifo_rd),
    .vld_o       (vld),
    .rdy_i       (rdy),
    .data_o      (data),
    .cnt_o       (cnt)
  );

  // Narrow-counter copy driven identically, used only for the wrap check.
  merlin_fifo_reader #(.C_WIDTH(32), .C_CNT_WIDTH(2)) dut_w2 (
    .clk_i       (clk_i),
    .resetb_i    (resetb),
    .clk_en_i    (clk_en),
    .flush_i     (flush),
    .fifo_empty_i(fifo_empty),
    .fifo_dout_i (fifo_dout),
    .fifo_rd_o   (fifo_rd2),
    .vld_o       (vld2),
    .rdy_i       (rdy),
    .data_o      (data2),
    .cnt_o       (cnt2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Monitor: checks count every cycle and pops the scoreboard on each accepted beat.
  always @(negedge clk_i) begin
    if (!resetb) begin
      exp_cnt = '0;
    end else begin
      check("cnt", {16'h0, cnt}, {16'h0, exp_cnt});
      if (fifo_rd) begin
        pops++;
        check("pop_while_empty", {31'h0, fifo_empty}, 32'h0);
      end
      if (clk_en && flush) begin
        exp_cnt = '0;
      end else if (clk_en && vld && rdy) begin
        if (sb.size() == 0) begin
          check("unexpected_beat", data, 32'hDEAD_BEEF);
        end else begin
          check("beat_data", data, sb.pop_front());
        end
        exp_cnt = exp_cnt + 16'd1;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    @(negedge clk_i);
    check("rst_vld", {31'h0, vld}, 32'h0);
    check("rst_data", data, 32'h0);
    check("rst_cnt", {16'h0, cnt}, 32'h0);
    check("rst_rd", {31'h0, fifo_rd}, 32'h0);
    step();
    resetb = 1'b1;
    rdy = 1'b1;

    // Idle with empty FIFO
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      check("idle_vld", {31'h0, vld}, 32'h0);
      check("idle_rd", {31'h0, fifo_rd}, 32'h0);
      step();
    end

    // Three beats at full rate
    wr = 1'b1; din = 32'h11; sb.push_back(32'h11);
    @(negedge clk_i);
    check("t2_rd_before_visible", {31'h0, fifo_rd}, 32'h0);
    step();
    din = 32'h22; sb.push_back(32'h22);
    @(negedge clk_i);
    check("t2_first_pop", {31'h0, fifo_rd}, 32'h1);
    check("t2_vld0", {31'h0, vld}, 32'h0);
    step();
    din = 32'h33; sb.push_back(32'h33);
    @(negedge clk_i);
    check("t2_vld1", {31'h0, vld}, 32'h1);
    step();
    wr = 1'b0;
    @(negedge clk_i);
    check("t2_vld2", {31'h0, vld}, 32'h1);
    step();
    @(negedge clk_i);
    check("t2_vld3", {31'h0, vld}, 32'h1);
    step();
    @(negedge clk_i);
    check("t2_vld_end", {31'h0, vld}, 32'h0);
    check("t2_cnt", {16'h0, cnt}, 32'd3);
    step();

    // Backpressure: only two pops fit
    rdy = 1'b0;
    pops = 0;
    for (int i = 0; i < 5; i++) begin
      wr = 1'b1; din = 32'hA0 + 32'(i); sb.push_back(din);
      step();
    end
    wr = 1'b0;
    step();
    step();
    check("bp_pops", 32'(pops), 32'd2);
    @(negedge clk_i);
    check("bp_rd", {31'h0, fifo_rd}, 32'h0);
    check("bp_occ", {30'h0, dut.occ_q}, {30'h0, OccTwo});
    check("bp_data", data, 32'hA0);
    check("bp_vld", {31'h0, vld}, 32'h1);
    step();
    @(negedge clk_i);
    check("bp_data_hold", data, 32'hA0);
    step();
    rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      check("bp_drain_vld", {31'h0, vld}, 32'h1);
      step();
    end
    @(negedge clk_i);
    check("bp_drain_end", {31'h0, vld}, 32'h0);
    check("bp_cnt", {16'h0, cnt}, 32'd8);
    step();

    // Flush while holding two entries
    rdy = 1'b0;
    wr = 1'b1; din = 32'hB0; sb.push_back(din);
    step();
    din = 32'hB1; sb.push_back(din);
    step();
    wr = 1'b0;
    step();
    @(negedge clk_i);
    check("fl_occ", {30'h0, dut.occ_q}, {30'h0, OccTwo});
    step();
    flush = 1'b1; rdy = 1'b1;
    sb.delete();
    @(negedge clk_i);
    check("fl_no_pop", {31'h0, fifo_rd}, 32'h0);
    step();
    flush = 1'b0;
    @(negedge clk_i);
    check("fl_vld", {31'h0, vld}, 32'h0);
    check("fl_cnt", {16'h0, cnt}, 32'h0);
    wr = 1'b1; din = 32'h55; sb.push_back(din);
    step();
    wr = 1'b0;
    @(negedge clk_i);
    check("fl_visible_rd", {31'h0, fifo_rd}, 32'h1);
    check("fl_visible_vld", {31'h0, vld}, 32'h0);
    step();
    @(negedge clk_i);
    check("fl_55_vld", {31'h0, vld}, 32'h1);
    check("fl_55_data", data, 32'h55);
    step();
    step();
    step();

    // Clock enable held low mid-stream
    for (int i = 0; i < 4; i++) begin
      wr = 1'b1; din = 32'hC0 + 32'(i); sb.push_back(din);
      step();
    end
    wr = 1'b0;
    clk_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      check("ce_rd", {31'h0, fifo_rd}, 32'h0);
      check("ce_data", data, 32'hC2);
      check("ce_cnt", {16'h0, cnt}, 32'd3);
      step();
    end
    clk_en = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("ce_drained", 32'(sb.size()), 32'd0);
    check("ce_cnt_after", {16'h0, cnt}, 32'd5);

    // Async reset mid-cycle with one entry held
    rdy = 1'b0;
    wr = 1'b1; din = 32'hD0; sb.push_back(din);
    step();
    wr = 1'b0;
    step();
    check("ar_occ", {30'h0, dut.occ_q}, {30'h0, OccOne});
    #2;
    resetb = 1'b0;
    #1;
    check("ar_vld", {31'h0, vld}, 32'h0);
    check("ar_data", data, 32'h0);
    check("ar_cnt", {16'h0, cnt}, 32'h0);
    check("ar_rd", {31'h0, fifo_rd}, 32'h0);
    sb.delete();
    step();
    resetb = 1'b1;

    // Five accepts on the 2-bit counter wrap to 1
    rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr = 1'b1; din = 32'hE0 + 32'(i); sb.push_back(din);
      step();
    end
    wr = 1'b0;
    for (int i = 0; i < 20 && sb.size() != 0; i++) step();
    step();
    check("wrap_cnt16", {16'h0, cnt}, 32'd5);
    check("wrap_cnt2", {30'h0, cnt2}, 32'd1);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
